// File: rtl/oled_spi_tx.sv
// Serialises one page-packed framebuffer as SSD1306-style SPI: invert command, then per page a
// page command followed by COLS data bytes. Two oled_clk cycles per bit, bytes back-to-back.
module oled_spi_tx #(
  parameter int PAGES = 8,
  parameter int COLS  = 128,
  parameter int AW    = 10
) (
  input  logic          oled_clk,
  input  logic          reset,
  input  logic          frame_req,
  input  logic          invert_in,
  output logic [AW-1:0] fb_addr,
  input  logic [7:0]    fb_data,
  output logic          spi_clk,
  output logic          oled_dc,
  output logic          oled_data,
  output logic          cs_n,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, CMD_INV, CMD_PAGE, DATA, FINISH} state_t;
  localparam int CW = AW - 3;

  state_t        state_q, state_d;
  logic          pend_q, phase_q;
  logic [2:0]    page_q, page_d, bit_q;
  logic [CW-1:0] col_q, col_d, col_inc;
  logic [6:0]    sh_q;
  logic [7:0]    byte_d, inv_byte;
  logic          dc_d;
  logic          spi_clk_q, dc_q, data_q, cs_n_q, busy_q, done_q;
  logic [AW-1:0] addr_q;

  assign inv_byte = {7'b1010011, invert_in};
  assign col_inc  = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);

  // col_q always names the next data byte to load, so col_q == 0 after a DATA byte
  // means the page's last column has just gone out.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    col_d   = col_q;
    byte_d  = 8'h00;
    dc_d    = 1'b0;
    case (state_q)
      CMD_INV: begin
        state_d = CMD_PAGE;
        byte_d  = 8'hB0 | {5'b0, page_q};
      end
      CMD_PAGE: begin
        state_d = DATA;
        byte_d  = fb_data;
        dc_d    = 1'b1;
        col_d   = col_inc;
      end
      DATA: begin
        if (col_q == '0) begin
          if (page_q == 3'(PAGES - 1)) begin
            state_d = FINISH;
          end else begin
            state_d = CMD_PAGE;
            page_d  = page_q + 3'd1;
            byte_d  = 8'hB0 | {5'b0, page_q + 3'd1};
          end
        end else begin
          byte_d = fb_data;
          dc_d   = 1'b1;
          col_d  = col_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge oled_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      phase_q   <= 1'b0;
      page_q    <= '0;
      col_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      spi_clk_q <= 1'b0;
      dc_q      <= 1'b0;
      data_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // The address trails page/col by one cycle; the next data byte is needed 16 cycles later.
      addr_q <= {page_q, col_q};
      case (state_q)
        IDLE, FINISH: begin
          if (frame_req || pend_q) begin
            state_q   <= CMD_INV;
            pend_q    <= 1'b0;
            page_q    <= '0;
            col_q     <= '0;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            spi_clk_q <= 1'b0;
            dc_q      <= 1'b0;
            data_q    <= inv_byte[7];
            sh_q      <= inv_byte[6:0];
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          if (frame_req) pend_q <= 1'b1;
          if (!phase_q) begin
            spi_clk_q <= 1'b1;
            phase_q   <= 1'b1;
          end else begin
            spi_clk_q <= 1'b0;
            phase_q   <= 1'b0;
            if (bit_q != 3'd7) begin
              bit_q  <= bit_q + 3'd1;
              data_q <= sh_q[6];
              sh_q   <= {sh_q[5:0], 1'b0};
            end else if (state_d == FINISH) begin
              state_q <= FINISH;
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              dc_q    <= 1'b0;
              data_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= state_d;
              page_q  <= page_d;
              col_q   <= col_d;
              bit_q   <= '0;
              dc_q    <= dc_d;
              data_q  <= byte_d[7];
              sh_q    <= byte_d[6:0];
            end
          end
        end
      endcase
    end
  end

  assign fb_addr   = addr_q;
  assign spi_clk   = spi_clk_q;
  assign oled_dc   = dc_q;
  assign oled_data = data_q;
  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
